fir_filter_param: RTL and testbench
===================================

// Module: fir_filter_param
// PURPOSE
//  Parametrised N-tap FIR engine: signed samples in, unsigned magnitude out.
//  Coefficients are loaded serially into a register bank. Each accepted sample is shifted into a delay line.
//  The dot product is computed with one multiply-accumulate (MAC) per cycle.
//  Sits between the sample/coefficient front-end (which owns the synchronisers) and the output magnitude consumer.
// PARAMETERS
//  DATA_W     16    sample and fir_out width
//  COEF_W     16    coefficient width, signed Q1.(COEF_W-1)
//  NTAPS      4     number of taps, >=2
//  SAMPLE_CNT 1000  samples per one_k_samples pulse
//  ACC_W      DATA_W+COEF_W+$clog2(NTAPS)  accumulator width (derived localparam)
// PORTS
//  clk              in   1       system clock, rising edge
//  rst              in   1       synchronous reset, active high
//  sample_data      in   DATA_W  signed sample, valid with data_ready
//  fir_coefficient  in   COEF_W  signed coefficient, valid with load_coeff
//  load_coeff       in   1       write fir_coefficient to c[coef_idx]; level, sampled each cycle
//  data_ready       in   1       new sample strobe (already synchronised to clk)
//  modwait          out  1       engine busy; new strobes are not accepted
//  coef_ready       out  1       all NTAPS coefficients loaded since reset
//  out_valid        out  1       one-cycle pulse; fir_out updated this cycle
//  fir_out          out  DATA_W  |y| saturated to 2^DATA_W-1
//  sat              out  1       last result was saturated
//  err              out  1       sticky protocol error
//  one_k_samples    out  1       one-cycle pulse every SAMPLE_CNT accepted samples
// BEHAVIOUR
//  Clock and reset: one clock, clk. Reset is synchronous and active-high (rst).
//  Reset: all outputs 0; delay line, coefficients, coef_idx, sample counter and acc cleared; state IDLE.
//  States:
//   IDLE: accepts strobes. load_coeff has priority over data_ready.
//    - load_coeff=1 -> LOAD.
//    - else data_ready=1 && coef_ready -> SHIFT.
//    - else data_ready=1 && !coef_ready -> err<=1, stay IDLE (sample dropped).
//   LOAD (1 cycle): c[coef_idx]<=fir_coefficient; coef_idx<=coef_idx+1 mod NTAPS.
//    - Set coef_ready when idx NTAPS-1 is written.
//    - modwait=1. Then WAITLC.
//   WAITLC: wait for load_coeff=0, then IDLE. One write per load_coeff high phase.
//   SHIFT (1 cycle): x[0]<=sample_data, x[i]<=x[i-1]; acc<=0; tap<=0; err<=0; modwait=1.
//    - Sample counter increments; one_k_samples pulses on the cycle it wraps SAMPLE_CNT-1 -> 0.
//   MAC (NTAPS cycles): acc<=acc+x[tap]*c[tap], signed full precision; tap++.
//    - Exit to OUT after tap NTAPS-1.
//   OUT (1 cycle): y = acc >>> (COEF_W-1) (arithmetic shift); m = |y|.
//    - fir_out<=min(m, 2^DATA_W-1); sat<=(m>2^DATA_W-1); out_valid=1; modwait=0 next cycle; -> IDLE.
//  Latency: data_ready sampled at edge T -> out_valid high in cycle T+NTAPS+2.
//   modwait is high for NTAPS+2 cycles (SHIFT, MAC, OUT).
//  Strobes while busy:
//   - data_ready in SHIFT/MAC/OUT/LOAD/WAITLC -> err<=1, sample dropped.
//   - load_coeff during SHIFT/MAC/OUT -> ignored, err<=1.
//  err is sticky; it clears only on the next accepted sample (SHIFT).
//  Coefficient reload mid-stream: allowed in IDLE; affects the next sample only.
//   coef_ready stays 1 once set.
//  y=-2^(ACC_W-COEF_W) magnitude must not wrap: compute |y| in ACC_W+1 bits.
//  rst asserted in any state: aborts the computation; no out_valid pulse.
// STRUCTURE
//  fir_pkg: state_t enum (IDLE, LOAD, WAITLC, SHIFT, MAC, OUT) and the ACC_W derivation function.
//  Sub-module fir_sample_counter: SAMPLE_CNT wrap counter, inputs inc/rst, output pulse.
//   The rest (FSM, delay line, coefficient bank, MAC, saturating magnitude) stays in fir_filter_param.
// TESTING (NTAPS=4, DATA_W=COEF_W=16)
//  1. Reset -> all outputs 0. data_ready before any coefficients -> err=1, no out_valid.
//  2. Load c=0x4000 x4 -> coef_ready=1. Samples 100,100,100,100 -> fir_out 50,100,150,200; out_valid 6 cycles after each strobe.
//  3. c={0x7FFF,0x7FFF,0x7FFF,0x7FFF}; four samples of -32768 -> fir_out=0xFFFF, sat=1; next sample 0 -> sat stays 1 (taps hold -32768).
//  4. data_ready pulsed during MAC -> err=1 and the sample is dropped. The next accepted sample clears err.
//  5. load_coeff and data_ready high together in IDLE -> coefficient written, err=1.
//   load_coeff held 5 cycles -> exactly one write.
//  6. SAMPLE_CNT=8: 16 samples -> one_k_samples pulses exactly twice, in the SHIFT cycle of samples 8 and 16.
//   rst during MAC -> no out_valid; state IDLE.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and width helpers for the FIR engine.
//  state_t  : engine FSM states
//  fir_acc_w: accumulator width, wide enough for NTAPS full-precision products
package fir_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WAITLC = 3'd2,
    SHIFT  = 3'd3,
    MAC    = 3'd4,
    OUT    = 3'd5
  } state_t;

  function automatic int fir_acc_w(input int data_w, input int coef_w, input int ntaps);
    return data_w + coef_w + $clog2(ntaps);
  endfunction

endpackage

// File: rtl/fir_filter_param_if.sv
// Sample/coefficient front-end to FIR engine bus.
//  master: front-end side (drives samples, coefficients, strobes)
//  slave : engine side (drives status, result, pulses)
interface fir_filter_param_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16
);
  logic [DATA_W-1:0] sample_data;
  logic [COEF_W-1:0] fir_coefficient;
  logic              load_coeff;
  logic              data_ready;
  logic              modwait;
  logic              coef_ready;
  logic              out_valid;
  logic [DATA_W-1:0] fir_out;
  logic              sat;
  logic              err;
  logic              one_k_samples;

  modport master (
    output sample_data, fir_coefficient, load_coeff, data_ready,
    input  modwait, coef_ready, out_valid, fir_out, sat, err, one_k_samples
  );

  modport slave (
    input  sample_data, fir_coefficient, load_coeff, data_ready,
    output modwait, coef_ready, out_valid, fir_out, sat, err, one_k_samples
  );
endinterface

// File: rtl/fir_sample_counter.sv
// Accepted-sample counter wrapping at SAMPLE_CNT.
//  clk, rst : clock, synchronous active-high reset
//  inc_i    : one accepted sample this cycle
//  pulse_o  : high in the cycle the count wraps SAMPLE_CNT-1 -> 0
module fir_sample_counter #(
  parameter int SAMPLE_CNT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  output logic pulse_o
);
  localparam int CNT_W = (SAMPLE_CNT > 1) ? $clog2(SAMPLE_CNT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_CNT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             wrap;

  assign wrap    = (cnt_q == LAST);
  assign pulse_o = inc_i && wrap;

  always_ff @(posedge clk) begin
    if (rst)        cnt_q <= '0;
    else if (inc_i) cnt_q <= wrap ? '0 : cnt_q + CNT_W'(1);
  end
endmodule

// File: rtl/fir_filter_param.sv
// N-tap FIR engine: serial coefficient load, sample delay line, one MAC
// per cycle, saturated magnitude of the Q-scaled result.
//  clk, rst : clock, synchronous active-high reset
//  bus      : slave side of fir_filter_param_if (strobes in, status/result out)
module fir_filter_param
  import fir_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int COEF_W     = 16,
  parameter int NTAPS      = 4,
  parameter int SAMPLE_CNT = 1000
) (
  input  logic                clk,
  input  logic                rst,
  fir_filter_param_if.slave   bus
);
  localparam int ACC_W = fir_acc_w(DATA_W, COEF_W, NTAPS);
  localparam int PW    = DATA_W + COEF_W;
  localparam int TAP_W = $clog2(NTAPS);
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NTAPS - 1);
  localparam logic [ACC_W:0]   MAXV     = {{(ACC_W + 1 - DATA_W){1'b0}}, {DATA_W{1'b1}}};

  state_t                         state_q;
  logic [NTAPS-1:0][DATA_W-1:0]   x_q;
  logic [NTAPS-1:0][COEF_W-1:0]   c_q;
  logic [DATA_W-1:0]              sample_q;
  logic [TAP_W-1:0]               idx_q, tap_q;
  logic signed [ACC_W-1:0]        acc_q;
  logic                           modwait_q, coef_ready_q, out_valid_q, sat_q, err_q;
  logic [DATA_W-1:0]              fir_out_q;

  logic signed [PW-1:0]           prod;
  logic signed [ACC_W-1:0]        acc_d, y;
  logic [ACC_W:0]                 y_ext, mag;
  logic                           sat_d;
  logic [DATA_W-1:0]              fir_out_d;
  logic                           one_k;

  // Result is formed from the final accumulation so it can be registered on
  // the last MAC edge and presented during OUT. Magnitude uses one extra bit
  // so the most negative y does not wrap.
  always_comb begin
    prod      = PW'($signed(x_q[tap_q])) * PW'($signed(c_q[tap_q]));
    acc_d     = acc_q + ACC_W'(prod);
    y         = acc_d >>> (COEF_W - 1);
    y_ext     = {y[ACC_W-1], y};
    mag       = y_ext[ACC_W] ? (~y_ext + (ACC_W + 1)'(1)) : y_ext;
    sat_d     = (mag > MAXV);
    fir_out_d = sat_d ? {DATA_W{1'b1}} : mag[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      x_q          <= '0;
      c_q          <= '0;
      sample_q     <= '0;
      idx_q        <= '0;
      tap_q        <= '0;
      acc_q        <= '0;
      modwait_q    <= 1'b0;
      coef_ready_q <= 1'b0;
      out_valid_q  <= 1'b0;
      sat_q        <= 1'b0;
      err_q        <= 1'b0;
      fir_out_q    <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.load_coeff) begin
            state_q   <= LOAD;
            modwait_q <= 1'b1;
            if (bus.data_ready) err_q <= 1'b1;
          end else if (bus.data_ready && coef_ready_q) begin
            state_q   <= SHIFT;
            sample_q  <= bus.sample_data;
            modwait_q <= 1'b1;
          end else if (bus.data_ready) begin
            err_q <= 1'b1;
          end
        end
        LOAD: begin
          c_q[idx_q] <= bus.fir_coefficient;
          idx_q      <= (idx_q == LAST_TAP) ? '0 : idx_q + TAP_W'(1);
          if (idx_q == LAST_TAP) coef_ready_q <= 1'b1;
          if (bus.data_ready)    err_q <= 1'b1;
          state_q <= WAITLC;
        end
        WAITLC: begin
          // one write per load_coeff high phase
          modwait_q <= bus.load_coeff;
          if (!bus.load_coeff) state_q <= IDLE;
          if (bus.data_ready)  err_q <= 1'b1;
        end
        SHIFT: begin
          x_q     <= {x_q[NTAPS-2:0], sample_q};
          acc_q   <= '0;
          tap_q   <= '0;
          err_q   <= bus.data_ready || bus.load_coeff;
          state_q <= MAC;
        end
        MAC: begin
          acc_q <= acc_d;
          tap_q <= tap_q + TAP_W'(1);
          if (bus.data_ready || bus.load_coeff) err_q <= 1'b1;
          if (tap_q == LAST_TAP) begin
            fir_out_q   <= fir_out_d;
            sat_q       <= sat_d;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end
        end
        OUT: begin
          modwait_q <= 1'b0;
          if (bus.data_ready || bus.load_coeff) err_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  fir_sample_counter #(.SAMPLE_CNT(SAMPLE_CNT)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (state_q == SHIFT),
    .pulse_o (one_k)
  );

  assign bus.modwait       = modwait_q;
  assign bus.coef_ready    = coef_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.fir_out       = fir_out_q;
  assign bus.sat           = sat_q;
  assign bus.err           = err_q;
  assign bus.one_k_samples = one_k;
endmodule

// File: tb/tb_fir_filter_param.sv
module tb_fir_filter_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0, n_fail = 0;
  int   ov_cnt = 0, ok_cnt = 0;

  fir_filter_param_if #(.DATA_W(16), .COEF_W(16)) bus ();

  fir_filter_param #(.DATA_W(16), .COEF_W(16), .NTAPS(4), .SAMPLE_CNT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // pulse monitors: values at posedge are those of the cycle just ending
  always @(posedge clk) begin
    if (bus.out_valid)     ov_cnt++;
    if (bus.one_k_samples) ok_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic load(input logic [15:0] c);
    bus.load_coeff = 1'b1; bus.fir_coefficient = c;
    tick(); tick();
    bus.load_coeff = 1'b0;
    tick();
  endtask

  // poke: 1 = data_ready strobe during MAC, 2 = load_coeff strobe during MAC
  task automatic do_sample(input logic [15:0] d, input int poke,
                           output logic [15:0] fo, output logic s,
                           output int lat, output logic onek);
    bus.sample_data = d; bus.data_ready = 1'b1;
    tick();
    bus.data_ready = 1'b0;
    lat  = 1;
    onek = bus.one_k_samples;
    while (!bus.out_valid && lat < 20) begin
      if (poke == 1 && lat == 2) begin bus.data_ready = 1'b1; bus.sample_data = 16'd5555; end
      if (poke == 2 && lat == 2) begin bus.load_coeff = 1'b1; bus.fir_coefficient = 16'h0000; end
      tick();
      bus.data_ready = 1'b0; bus.load_coeff = 1'b0;
      lat++;
    end
    fo = bus.fir_out; s = bus.sat;
    tick();
  endtask

  task automatic smp(input string tag, input logic [15:0] d, input int poke,
                     input logic [15:0] exp_o, input logic exp_s);
    logic [15:0] fo; logic s; int lat; logic k;
    do_sample(d, poke, fo, s, lat, k);
    chk({tag, " latency"}, 32'(lat), 32'd6);
    chk({tag, " fir_out"}, 32'(fo), 32'(exp_o));
    chk({tag, " sat"},     32'(s),  32'(exp_s));
    chk({tag, " out_valid one cycle"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int ov0, ok0;
    logic [15:0] fo; logic s; int lat; logic k;
    bus.sample_data = '0; bus.fir_coefficient = '0;
    bus.load_coeff = 1'b0; bus.data_ready = 1'b0;

    // 1. reset state, sample before coefficients
    tick(); tick(); tick();
    chk("reset outputs", 32'({bus.modwait, bus.coef_ready, bus.out_valid, bus.fir_out,
                              bus.sat, bus.err, bus.one_k_samples}), 32'd0);
    rst = 1'b0;
    ov0 = ov_cnt;
    bus.sample_data = 16'd77; bus.data_ready = 1'b1;
    tick();
    bus.data_ready = 1'b0;
    chk("early sample err", 32'(bus.err), 32'd1);
    chk("early sample modwait", 32'(bus.modwait), 32'd0);
    repeat (8) tick();
    chk("early sample no out_valid", 32'(ov_cnt - ov0), 32'd0);

    // 2. c = 0.5 x4, constant input ramps the output
    load(16'h4000); load(16'h4000); load(16'h4000);
    chk("coef_ready after 3", 32'(bus.coef_ready), 32'd0);
    load(16'h4000);
    chk("coef_ready after 4", 32'(bus.coef_ready), 32'd1);
    smp("s100a", 16'd100, 0, 16'd50, 1'b0);
    chk("err cleared by sample", 32'(bus.err), 32'd0);
    smp("s100b", 16'd100, 0, 16'd100, 1'b0);
    smp("s100c", 16'd100, 0, 16'd150, 1'b0);
    smp("s100d", 16'd100, 0, 16'd200, 1'b0);

    // 3. max coefficients, most negative samples -> saturation
    repeat (4) load(16'h7FFF);
    smp("neg1", 16'h8000, 0, 16'd32468, 1'b0);
    smp("neg2", 16'h8000, 0, 16'd65335, 1'b0);
    smp("neg3", 16'h8000, 0, 16'hFFFF, 1'b1);
    smp("neg4", 16'h8000, 0, 16'hFFFF, 1'b1);
    smp("zero after neg", 16'd0, 0, 16'hFFFF, 1'b1);

    // 4. strobes while busy
    smp("lc during MAC", 16'd1000, 2, 16'd64535, 1'b0);
    chk("lc during MAC err", 32'(bus.err), 32'd1);
    smp("s2000", 16'd2000, 0, 16'd29768, 1'b0);
    chk("err cleared", 32'(bus.err), 32'd0);
    smp("dr during MAC", 16'd3000, 1, 16'd5999, 1'b0);
    chk("dr during MAC err", 32'(bus.err), 32'd1);
    smp("after dropped", 16'd4000, 0, 16'd9999, 1'b0);
    chk("err cleared again", 32'(bus.err), 32'd0);

    // 5. load + data_ready together, then a 5-cycle load_coeff
    bus.load_coeff = 1'b1; bus.fir_coefficient = 16'h0000;
    bus.data_ready = 1'b1; bus.sample_data = 16'd7;
    tick();
    bus.data_ready = 1'b0;
    tick();
    bus.load_coeff = 1'b0;
    tick();
    chk("load+dr err", 32'(bus.err), 32'd1);
    bus.load_coeff = 1'b1;
    repeat (5) tick();
    chk("held load busy", 32'(bus.modwait), 32'd1);
    bus.load_coeff = 1'b0;
    tick(); tick();
    chk("held load idle", 32'(bus.modwait), 32'd0);
    chk("coef_ready sticky", 32'(bus.coef_ready), 32'd1);
    smp("one write", 16'd0, 0, 16'd4999, 1'b0);

    // 6. sample counter wrap every 8 samples
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    chk("reset2 outputs", 32'({bus.modwait, bus.coef_ready, bus.out_valid, bus.fir_out,
                               bus.sat, bus.err, bus.one_k_samples}), 32'd0);
    repeat (4) load(16'h4000);
    ok0 = ok_cnt;
    for (int i = 1; i <= 16; i++) begin
      do_sample(16'(i), 0, fo, s, lat, k);
      chk($sformatf("one_k sample %0d", i), 32'(k), 32'((i == 8) || (i == 16)));
    end
    chk("one_k pulse count", 32'(ok_cnt - ok0), 32'd2);

    // reset in the middle of MAC aborts without a result
    ov0 = ov_cnt;
    bus.sample_data = 16'd1; bus.data_ready = 1'b1;
    tick();
    bus.data_ready = 1'b0;
    tick(); tick();
    chk("busy before abort", 32'(bus.modwait), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (10) tick();
    chk("abort no out_valid", 32'(ov_cnt - ov0), 32'd0);
    chk("abort idle", 32'(bus.modwait), 32'd0);
    chk("abort coef cleared", 32'(bus.coef_ready), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
